// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter
// Purpose  : Round-robin sharing of one board SPI bus (SCK/MOSI) between
//            NUM_REQ masters. The arbiter owns every peripheral chip-select
//            and frames each tenure with SETUP/HOLD guard cycles plus a
//            one-clock all-CS-high gap.
// Ports    : clk_i, rst_n_i (async, active-low)
//            req_i / cs_sel_i / sck_i / mosi_i : per-master request, 3-bit CS
//                                                index, SCK and MOSI
//            gnt_o (one-hot), sck_o, mosi_o, cs_n_o (active-low)
//            busy_o, owner_o, timeout_o
// Options  : `define SPI_ARB_TIMEOUT_EN builds the TIMEOUT_CYCLES ownership
//            limit; without it timeout_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter #(
    parameter int   NUM_REQ        = 2,
    parameter int   CS_COUNT       = 6,
    parameter int   SETUP_CYCLES   = 2,
    parameter int   HOLD_CYCLES    = 2,
    parameter logic SCK_IDLE       = 1'b0,
    parameter int   TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [3*NUM_REQ-1:0] cs_sel_i,
    input  logic [NUM_REQ-1:0]   sck_i,
    input  logic [NUM_REQ-1:0]   mosi_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic                 sck_o,
    output logic                 mosi_o,
    output logic [CS_COUNT-1:0]  cs_n_o,
    output logic                 busy_o,
    output logic [1:0]           owner_o,
    output logic                 timeout_o
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_OWN   = 3'd2;
    localparam logic [2:0] c_HOLD  = 3'd3;
    localparam logic [2:0] c_GAP   = 3'd4;

    localparam logic [3:0] c_SETUP_LAST = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] c_HOLD_LAST  = 4'(HOLD_CYCLES - 1);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 4 || CS_COUNT < 1 || CS_COUNT > 8 ||
            SETUP_CYCLES < 1 || SETUP_CYCLES > 15 ||
            HOLD_CYCLES < 1 || HOLD_CYCLES > 15 ||
            TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
            $error("spi_bus_arbiter: parameter out of range");
        end
    endgenerate

    // Registered state
    logic [2:0]          r_state;
    logic [3:0]          r_cnt;
    logic [1:0]          r_owner;
    logic [2:0]          r_cs_idx;
    logic [1:0]          r_rr_ptr;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [CS_COUNT-1:0] r_cs_n;
    logic                r_busy;
    logic                r_timeout;

    // Combinational next values
    logic [2:0]          w_state_nxt;
    logic [3:0]          w_cnt_nxt;
    logic [1:0]          w_owner_nxt;
    logic [2:0]          w_cs_idx_nxt;
    logic [1:0]          w_rr_nxt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [CS_COUNT-1:0] w_cs_n_nxt;
    logic                w_busy_nxt;
    logic                w_active;
    logic                w_to_fire;
    logic                w_to_hit;

    // Arbitration / owner selection
    logic [NUM_REQ-1:0]  w_mask;
    logic [NUM_REQ-1:0]  w_valid;
    logic                w_found;
    logic                w_found_hi;
    logic [1:0]          w_win_hi;
    logic [1:0]          w_win_lo;
    logic [1:0]          w_win;
    logic [2:0]          w_win_sel;
    logic                w_own_req;
    logic                w_own_sck;
    logic                w_own_mosi;

    // Round robin: the lowest valid index at or above rr_ptr wins; if there
    // is none, the search wraps and the lowest valid index overall wins.
    always_comb begin
        w_valid    = '0;
        w_found    = 1'b0;
        w_found_hi = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        w_win_sel  = '0;
        w_own_req  = 1'b0;
        w_own_sck  = SCK_IDLE;
        w_own_mosi = 1'b1;
        for (int n = NUM_REQ - 1; n >= 0; n--) begin
            w_valid[n] = req_i[n] && !w_mask[n] &&
                         (int'(cs_sel_i[3*n +: 3]) < CS_COUNT);
            if (w_valid[n]) begin
                w_found  = 1'b1;
                w_win_lo = 2'(n);
                if (n >= int'(r_rr_ptr)) begin
                    w_found_hi = 1'b1;
                    w_win_hi   = 2'(n);
                end
            end
        end
        w_win = w_found_hi ? w_win_hi : w_win_lo;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (w_win == 2'(n)) begin
                w_win_sel = cs_sel_i[3*n +: 3];
            end
            if (r_owner == 2'(n)) begin
                w_own_req  = req_i[n];
                w_own_sck  = sck_i[n];
                w_own_mosi = mosi_i[n];
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0]        r_to_cnt;
    logic [NUM_REQ-1:0] r_mask;
    logic [NUM_REQ-1:0] w_to_set;

    assign w_to_hit = (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign w_mask   = r_mask;

    always_comb begin
        w_to_set = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            w_to_set[n] = w_to_fire && (r_owner == 2'(n));
        end
    end

    // Counter sits at zero outside OWN, so it is clear on OWN entry. A
    // timed-out master stays masked until its request is seen low.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_to_cnt <= '0;
            r_mask   <= '0;
        end else begin
            if (r_state != c_OWN) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
            r_mask <= (r_mask | w_to_set) & req_i;
        end
    end
`else
    assign w_to_hit = 1'b0;
    assign w_mask   = '0;
`endif

    // State register and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_owner   <= '0;
            r_cs_idx  <= '0;
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_cs_n    <= '1;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_owner   <= w_owner_nxt;
            r_cs_idx  <= w_cs_idx_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_to_fire;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_owner_nxt  = r_owner;
        w_cs_idx_nxt = r_cs_idx;
        w_rr_nxt     = r_rr_ptr;
        w_to_fire    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = c_SETUP;
                    w_owner_nxt  = w_win;
                    w_cs_idx_nxt = w_win_sel;
                    w_cnt_nxt    = '0;
                end
            end
            c_SETUP: begin
                // A request dropped during setup aborts without a grant.
                if (!w_own_req) begin
                    w_state_nxt = c_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_SETUP_LAST) begin
                    w_state_nxt = c_OWN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            c_OWN: begin
                if (!w_own_req) begin
                    w_state_nxt = c_HOLD;
                    w_cnt_nxt   = '0;
                end else if (w_to_hit) begin
                    w_state_nxt = c_HOLD;
                    w_cnt_nxt   = '0;
                    w_to_fire   = 1'b1;
                end
            end
            c_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_state_nxt = c_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            c_GAP: begin
                w_state_nxt = c_IDLE;
                w_rr_nxt    = (r_owner == 2'(NUM_REQ - 1)) ? 2'd0 : r_owner + 2'd1;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Output logic: registered outputs are decoded from the next state;
    // SCK/MOSI are a zero-latency mux from the registered owner.
    always_comb begin
        w_active   = (w_state_nxt == c_SETUP) || (w_state_nxt == c_OWN) ||
                     (w_state_nxt == c_HOLD);
        w_busy_nxt = (w_state_nxt != c_IDLE);
        w_gnt_nxt  = '0;
        w_cs_n_nxt = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gnt_nxt[i] = (w_state_nxt == c_OWN) && (w_owner_nxt == 2'(i));
        end
        for (int i = 0; i < CS_COUNT; i++) begin
            w_cs_n_nxt[i] = !(w_active && (w_cs_idx_nxt == 3'(i)));
        end
        sck_o  = (r_state == c_OWN) ? w_own_sck  : SCK_IDLE;
        mosi_o = (r_state == c_OWN) ? w_own_mosi : 1'b1;
    end

    assign gnt_o     = r_gnt;
    assign cs_n_o    = r_cs_n;
    assign busy_o    = r_busy;
    assign owner_o   = r_owner;
    assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_bus_arbiter
// Purpose  : Self-checking bench for spi_bus_arbiter. A tenure-level model
//            (start edge, release edge, guard intervals) predicts every
//            output after each clock edge under random master behaviour,
//            plus directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_bus_arbiter;

    localparam int   NR  = 2;
    localparam int   CSN = 6;
    localparam int   SU  = 2;
    localparam int   HD  = 2;
    localparam int   TO  = 100;
    localparam logic SI  = 1'b0;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req   = '0;
    logic [3*NR-1:0] sel   = '0;
    logic [NR-1:0]   sck   = '0;
    logic [NR-1:0]   mosi  = '0;

    logic [NR-1:0]   gnt;
    logic            sck_o;
    logic            mosi_o;
    logic [CSN-1:0]  cs_n;
    logic            busy;
    logic [1:0]      owner;
    logic            tmo;

    spi_bus_arbiter #(
        .NUM_REQ        (NR),
        .CS_COUNT       (CSN),
        .SETUP_CYCLES   (SU),
        .HOLD_CYCLES    (HD),
        .SCK_IDLE       (SI),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .cs_sel_i  (sel),
        .sck_i     (sck),
        .mosi_i    (mosi),
        .gnt_o     (gnt),
        .sck_o     (sck_o),
        .mosi_o    (mosi_o),
        .cs_n_o    (cs_n),
        .busy_o    (busy),
        .owner_o   (owner),
        .timeout_o (tmo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- tenure-level reference model ----------------
    int          cyc = 0;
    bit          m_ten;
    int          m_start;
    int          m_rel;
    bit          m_to_now;
    int          m_owner;
    int          m_cs;
    int          m_ptr;
    logic [NR-1:0] m_mask;

    function automatic bit bit_of(input logic [NR-1:0] v, input int i);
        return |((v >> i) & NR'(1));
    endfunction

    function automatic int sel_of(input int i);
        return int'((sel >> (3*i)) & 6'h7);
    endfunction

    task automatic model_reset();
        m_ten    = 1'b0;
        m_start  = 0;
        m_rel    = -1;
        m_to_now = 1'b0;
        m_owner  = 0;
        m_cs     = 0;
        m_ptr    = 0;
        m_mask   = '0;
    endtask

    task automatic model_step();
        bit found;
        cyc++;
        m_to_now = 1'b0;
        found    = 1'b0;
        if (m_ten) begin
            if (m_rel < 0) begin
                if (!bit_of(req, m_owner)) begin
                    m_rel = cyc;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cyc == m_start + SU + TO) begin
                    m_rel    = cyc;
                    m_to_now = 1'b1;
                end
`endif
            end else if (cyc == m_rel + HD + 1) begin
                m_ten = 1'b0;
                m_ptr = (m_owner + 1) % NR;
            end
        end else begin
            for (int k = 0; k < NR; k++) begin
                int n;
                n = (m_ptr + k) % NR;
                if (!found && bit_of(req, n) && !bit_of(m_mask, n) && sel_of(n) < CSN) begin
                    found   = 1'b1;
                    m_owner = n;
                    m_cs    = sel_of(n);
                end
            end
            if (found) begin
                m_ten   = 1'b1;
                m_start = cyc;
                m_rel   = -1;
            end
        end
        if (m_to_now) begin
            m_mask = m_mask | (NR'(1) << m_owner);
        end
        m_mask = m_mask & req;
    endtask

    task automatic check_outputs();
        logic [NR-1:0]  eg;
        logic [CSN-1:0] ec;
        bit             own;
        own = m_ten && (m_rel < 0) && (cyc >= m_start + SU);
        eg  = own ? (NR'(1) << m_owner) : '0;
        ec  = (m_ten && (m_rel < 0 || cyc < m_rel + HD)) ? ~(CSN'(1) << m_cs) : '1;
        chk("gnt", gnt, eg);
        chk("cs_n", cs_n, ec);
        chk("busy", busy, m_ten);
        chk("owner", owner, m_owner);
        chk("timeout", tmo, m_to_now);
        chk("sck", sck_o, own ? bit_of(sck, m_owner) : SI);
        chk("mosi", mosi_o, own ? bit_of(mosi, m_owner) : 1'b1);
    endtask

    // One clock: model and DUT advance on the edge, outputs compared 1 time
    // unit later, control returns at the falling edge for new stimulus.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic set_sel(input int n, input int s);
        sel = (sel & ~(6'h7 << (3*n))) | (6'(s) << (3*n));
    endtask

    task automatic settle();
        req = '0;
        repeat (8) tick();
    endtask

    initial begin
        int seen;
        int seen1;
        bit got;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_gnt", gnt, 0);
        chk("rst_cs_n", cs_n, 6'h3F);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_sck", sck_o, SI);
        chk("rst_mosi", mosi_o, 1);

        // Single request, CS index 3
        req = 2'b01;
        set_sel(0, 3);
        tick();
        chk("single_cs_fall", cs_n, 6'h37);
        chk("single_busy", busy, 1);
        tick();
        chk("single_no_gnt_yet", gnt, 0);
        tick();
        chk("single_gnt", gnt, 2'b01);
        repeat (2) begin
            sck = 2'b10; mosi = 2'b10;
            tick();
            chk("mux_other_sck", sck_o, 0);
            chk("mux_other_mosi", mosi_o, 0);
            sck = 2'b01; mosi = 2'b01;
            tick();
            chk("mux_own_sck", sck_o, 1);
        end
        req = 2'b00;
        tick();
        chk("rel_gnt_clear", gnt, 0);
        chk("rel_cs_held", cs_n, 6'h37);
        tick();
        chk("rel_cs_held2", cs_n, 6'h37);
        tick();
        chk("rel_cs_rise", cs_n, 6'h3F);
        chk("rel_busy_gap", busy, 1);
        tick();
        chk("rel_busy_low", busy, 0);

        // Invalid index on master 0, valid on master 1
        set_sel(0, 7);
        set_sel(1, 0);
        req = 2'b11;
        repeat (4) tick();
        chk("inv_gnt_m1", gnt, 2'b10);
        chk("inv_cs0", cs_n, 6'h3E);
        repeat (10) tick();
        settle();

        // Owner 1 mux check: only master 1's lines reach the bus
        set_sel(1, 4);
        req = 2'b10;
        repeat (3) tick();
        sck = 2'b10; mosi = 2'b00;
        #1;
        chk("mux1_sck", sck_o, 1);
        chk("mux1_mosi", mosi_o, 0);
        sck = 2'b01; mosi = 2'b10;
        #1;
        chk("mux1_sck_other", sck_o, 0);
        chk("mux1_mosi2", mosi_o, 1);
        @(negedge clk);
        tick();
        settle();

        // Abort during setup
        set_sel(0, 2);
        req = 2'b01;
        tick();
        req = 2'b00;
        seen = 0;
        repeat (6) begin
            tick();
            if (gnt != 0) seen++;
        end
        chk("abort_no_gnt", seen, 0);
        settle();

        // Random masters
        for (int t = 0; t < 3000; t++) begin
            for (int n = 0; n < NR; n++) begin
                if (!bit_of(req, n)) begin
                    if ($urandom_range(3) == 0) begin
                        req = req | (NR'(1) << n);
                        set_sel(n, ($urandom_range(7) == 0) ? 7 : int'($urandom_range(5)));
                    end
                end else begin
                    if ($urandom_range(11) == 0) begin
                        req = req & ~(NR'(1) << n);
                    end else if ($urandom_range(15) == 0) begin
                        set_sel(n, int'($urandom_range(7)));
                    end
                end
            end
            sck  = NR'($urandom);
            mosi = NR'($urandom);
            tick();
        end
        settle();

`ifdef SPI_ARB_TIMEOUT_EN
        // Master 0 holds far beyond the limit with master 1 pending
        set_sel(0, 1);
        set_sel(1, 2);
        req = 2'b01;
        tick();
        req = 2'b11;
        seen  = 0;
        seen1 = 0;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (tmo) seen++;
            if (gnt == 2'b10) seen1 = 1;
        end
        chk("to_pulses", seen, 1);
        chk("to_m1_granted", seen1, 1);
        settle();
`endif

        // Asynchronous reset during OWN
        set_sel(0, 5);
        req = 2'b01;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            if (gnt == 2'b01) got = 1'b1;
        end
        chk("arst_wait_gnt", got, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cs_n", cs_n, 6'h3F);
        chk("arst_gnt", gnt, 0);
        chk("arst_busy", busy, 0);
        req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
